// File: rtl/pp_serial_accumulator.sv
// Purpose: shift-add accumulator turning a stream of (W+1)-bit partial-product
//          rows (LSB row first) into a 2W-bit product; SIGNED=1 subtracts the last row.
// Latency: prod_valid rises the cycle after the last row is accepted; W+1 cycles min per product.
// Backpressure: pp_ready=0 while a product waits; prod/err held until prod_ready.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   pp_valid/pp_ready partial-product row handshake (pp, pp_last)
//   prod_valid/prod_ready product handshake (prod, err)
//
// Optional feature: define PP_ACC_LEN_CHECK_EN to count rows per frame. A frame
// ending early flags err; a W-th row without pp_last is forced to be the last
// row and flags err. Without the macro err is tied low.
module pp_serial_accumulator #(
  parameter int W      = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pp_valid,
  output logic           pp_ready,
  input  logic [W:0]     pp,
  input  logic           pp_last,
  output logic           prod_valid,
  input  logic           prod_ready,
  output logic [2*W-1:0] prod,
  output logic           err
);

  typedef enum logic [0:0] {ST_ACC, ST_OUT} state_t;

  state_t         state_q, state_d;
  logic [W:0]     acc_hi;
  logic [W-1:0]   acc_lo;
  logic [W+1:0]   operand_raw, operand, sum;
  logic           accept;
  logic           eff_last;

`ifdef PP_ACC_LEN_CHECK_EN
  localparam int CW = $clog2(W+1);
  logic [CW-1:0]  count;
  logic           final_slot;
  logic           row_err;
  logic           err_q;

  // The row about to be accepted is the W-th one of the frame.
  assign final_slot = (count == CW'(W-1));
  assign eff_last   = pp_last | final_slot;
  // Either the frame ends early or it runs past W rows without pp_last.
  assign row_err    = pp_last ^ final_slot;
  assign err        = err_q;
`else
  assign eff_last   = pp_last;
  assign err        = 1'b0;
`endif

  assign accept = pp_valid & pp_ready;

  always_comb begin
    operand_raw = SIGNED ? {pp[W], pp} : {2'b00, pp[W-1:0]};
    // Two's-complement multiplier: the MSB row carries negative weight.
    operand     = (SIGNED && eff_last) ? -operand_raw : operand_raw;
    // W+2 bits hold sext(acc_hi) plus or minus a (W+1)-bit row without overflow.
    sum         = {acc_hi[W], acc_hi} + operand;
  end

  always_comb begin
    state_d    = state_q;
    pp_ready   = 1'b0;
    prod_valid = 1'b0;
    case (state_q)
      ST_ACC: begin
        pp_ready = 1'b1;
        if (accept && eff_last) state_d = ST_OUT;
      end
      ST_OUT: begin
        prod_valid = 1'b1;
        if (prod_ready) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_hi <= '0;
      acc_lo <= '0;
      prod   <= '0;
    end else if (state_q == ST_ACC) begin
      if (accept) begin
        acc_hi <= sum[W+1:1];
        acc_lo <= {sum[0], acc_lo[W-1:1]};
        // Snapshot of the post-shift {acc_hi[W-1:0], acc_lo}.
        if (eff_last) prod <= {sum[W:1], sum[0], acc_lo[W-1:1]};
      end
    end else if (prod_ready) begin
      acc_hi <= '0;
      acc_lo <= '0;
    end
  end

`ifdef PP_ACC_LEN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      err_q <= 1'b0;
    end else if (state_q == ST_ACC) begin
      if (accept) begin
        count <= count + CW'(1);
        if (eff_last) err_q <= row_err;
      end
    end else if (prod_ready) begin
      count <= '0;
      err_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pp_serial_accumulator.sv
module tb_pp_serial_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic        prdy;
  logic        last_d;
  logic [16:0] pp_bus;
  logic [1:0]  sel;   // 0: W4 signed, 1: W4 unsigned, 2: W16 signed, 3: W16 unsigned

  logic [3:0]  vld_v, prdy_v, rdy_v, pv_v, err_v;
  logic [7:0]  prod_s4, prod_u4;
  logic [31:0] prod_s16, prod_u16;
  logic [31:0] prod_a [4];

  logic        cur_rdy, cur_pv, cur_err;
  logic [31:0] cur_prod;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always_comb begin
    vld_v  = '0;
    prdy_v = '0;
    vld_v[sel]  = vld;
    prdy_v[sel] = prdy;
  end

  assign prod_a[0] = {24'b0, prod_s4};
  assign prod_a[1] = {24'b0, prod_u4};
  assign prod_a[2] = prod_s16;
  assign prod_a[3] = prod_u16;
  assign cur_rdy   = rdy_v[sel];
  assign cur_pv    = pv_v[sel];
  assign cur_err   = err_v[sel];
  assign cur_prod  = prod_a[sel];

  pp_serial_accumulator #(.W(4), .SIGNED(1'b1)) u_s4 (
    .clk(clk), .rst(rst), .pp_valid(vld_v[0]), .pp_ready(rdy_v[0]), .pp(pp_bus[4:0]),
    .pp_last(last_d), .prod_valid(pv_v[0]), .prod_ready(prdy_v[0]), .prod(prod_s4), .err(err_v[0]));
  pp_serial_accumulator #(.W(4), .SIGNED(1'b0)) u_u4 (
    .clk(clk), .rst(rst), .pp_valid(vld_v[1]), .pp_ready(rdy_v[1]), .pp(pp_bus[4:0]),
    .pp_last(last_d), .prod_valid(pv_v[1]), .prod_ready(prdy_v[1]), .prod(prod_u4), .err(err_v[1]));
  pp_serial_accumulator #(.W(16), .SIGNED(1'b1)) u_s16 (
    .clk(clk), .rst(rst), .pp_valid(vld_v[2]), .pp_ready(rdy_v[2]), .pp(pp_bus),
    .pp_last(last_d), .prod_valid(pv_v[2]), .prod_ready(prdy_v[2]), .prod(prod_s16), .err(err_v[2]));
  pp_serial_accumulator #(.W(16), .SIGNED(1'b0)) u_u16 (
    .clk(clk), .rst(rst), .pp_valid(vld_v[3]), .pp_ready(rdy_v[3]), .pp(pp_bus),
    .pp_last(last_d), .prod_valid(pv_v[3]), .prod_ready(prdy_v[3]), .prod(prod_u16), .err(err_v[3]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present one row and hold it until it is accepted. Returns #1 after the accepting edge.
  task automatic send_row(input logic [16:0] v, input logic last);
    int n = 0;
    pp_bus = v;
    last_d = last;
    vld    = 1'b1;
    while (!cur_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("row_accept_timeout", 64'(cur_rdy), 64'd1);
    @(posedge clk); #1;
    vld    = 1'b0;
    last_d = 1'b0;
  endtask

  // Wait for the product, optionally stall, check it, then hand it off.
  task automatic get_prod(input string tag, input logic [31:0] exp, input logic exp_err, input int stall);
    int n = 0;
    while (!cur_pv && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 64'(cur_pv), 64'd1);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    check({tag, "_prod"}, 64'(cur_prod), 64'(exp));
    check({tag, "_err"}, 64'(cur_err), 64'(exp_err));
    prdy = 1'b1;
    @(posedge clk); #1;
    prdy = 1'b0;
    check({tag, "_rdy_after"}, 64'(cur_rdy), 64'd1);
  endtask

  function automatic longint sx(longint v, int w);
    return v[w-1] ? v - (longint'(1) << w) : v;
  endfunction

  // Partial-product row for multiplier bit i: y (extended) or 0; junk goes to the
  // ignored top bit in unsigned mode.
  function automatic logic [16:0] mk_row(int w, bit s, logic [15:0] x, logic [15:0] y, int i, bit junk);
    logic [16:0] ym;
    logic [16:0] top;
    ym  = 17'(y) & ((17'd1 << w) - 17'd1);
    top = 17'd1 << w;
    if (s) return x[i] ? (ym | (y[w-1] ? top : 17'd0)) : 17'd0;
    return (x[i] ? ym : 17'd0) | (junk ? top : 17'd0);
  endfunction

  initial begin
    logic [16:0] r1d, r03;
    rst = 1'b1; vld = 1'b0; prdy = 1'b0; last_d = 1'b0; pp_bus = '0; sel = 2'd0;
    r1d = 17'h1D;
    r03 = 17'h03;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      check("rst_pp_ready", 64'(cur_rdy), 64'd1);
      check("rst_prod_valid", 64'(cur_pv), 64'd0);
      check("rst_prod", 64'(cur_prod), 64'd0);
      check("rst_err", 64'(cur_err), 64'd0);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    sel = 2'd0;
    #1;
    check("post_rst_pp_ready", 64'(cur_rdy), 64'd1);

    // y=-3, x=0101 -> -15
    send_row(r1d, 1'b0); send_row(17'h0, 1'b0); send_row(r1d, 1'b0); send_row(17'h0, 1'b1);
    check("c1_latency", 64'(cur_pv), 64'd1);
    check("c1_pp_ready_low", 64'(cur_rdy), 64'd0);
    get_prod("c1", 32'hF1, 1'b0, 0);

    // y=3, x=-1 -> -3
    for (int i = 0; i < 4; i++) send_row(r03, i == 3);
    get_prod("c2", 32'hFD, 1'b0, 0);

    // y=-8, x=-8 -> +64
    send_row(17'h0, 1'b0); send_row(17'h0, 1'b0); send_row(17'h0, 1'b0); send_row(17'h18, 1'b1);
    get_prod("c3", 32'h40, 1'b0, 0);

    // unsigned 15*15 with pp[4] set
    sel = 2'd1;
    for (int i = 0; i < 4; i++) send_row(17'h1F, i == 3);
    get_prod("c4", 32'hE1, 1'b0, 0);

    // backpressure: product held, next frame's first row waiting
    sel = 2'd0;
    send_row(r1d, 1'b0); send_row(17'h0, 1'b0); send_row(r1d, 1'b0); send_row(17'h0, 1'b1);
    pp_bus = r03; last_d = 1'b0; vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("c5_hold_prod", 64'(cur_prod), 64'hF1);
      check("c5_hold_rdy", 64'(cur_rdy), 64'd0);
      check("c5_hold_valid", 64'(cur_pv), 64'd1);
    end
    prdy = 1'b1;
    @(posedge clk); #1;
    prdy = 1'b0;
    check("c5_handoff_valid", 64'(cur_pv), 64'd0);
    check("c5_handoff_rdy", 64'(cur_rdy), 64'd1);
    for (int i = 0; i < 4; i++) send_row(r03, i == 3);
    get_prod("c5_next", 32'hFD, 1'b0, 0);

    // reset mid-frame discards the partial sum
    send_row(r1d, 1'b0); send_row(17'h0, 1'b0);
    #2 rst = 1'b1;
    #2;
    check("c6_rst_valid", 64'(cur_pv), 64'd0);
    check("c6_rst_rdy", 64'(cur_rdy), 64'd1);
    check("c6_rst_prod", 64'(cur_prod), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    send_row(r1d, 1'b0); send_row(17'h0, 1'b0); send_row(r1d, 1'b0); send_row(17'h0, 1'b1);
    get_prod("c6", 32'hF1, 1'b0, 0);

`ifdef PP_ACC_LEN_CHECK_EN
    // short frame: last on row 2
    send_row(r1d, 1'b0); send_row(17'h0, 1'b1);
    check("len_short_valid", 64'(cur_pv), 64'd1);
    check("len_short_err", 64'(cur_err), 64'd1);
    prdy = 1'b1;
    @(posedge clk); #1;
    prdy = 1'b0;
    check("len_short_cleared", 64'(cur_err), 64'd0);
    // no pp_last: row 4 is forced to be last
    send_row(r1d, 1'b0); send_row(17'h0, 1'b0); send_row(r1d, 1'b0); send_row(17'h0, 1'b0);
    check("len_long_valid", 64'(cur_pv), 64'd1);
    get_prod("len_long", 32'hF1, 1'b1, 0);
    for (int i = 0; i < 4; i++) send_row(r03, i == 3);
    get_prod("len_after", 32'hFD, 1'b0, 0);
`endif

    // randomized frames on every configuration
    for (int d = 0; d < 4; d++) begin
      int  w;
      bit  s;
      sel = 2'(d);
      w   = d[1] ? 16 : 4;
      s   = !d[0];
      for (int f = 0; f < 25; f++) begin
        logic [15:0] x, y, mask;
        longint a, b, p;
        mask = 16'((32'd1 << w) - 32'd1);
        if (f == 0) begin
          x = 16'(1 << (w-1)); y = x;
        end else if (f == 1) begin
          x = mask; y = mask;
        end else begin
          x = 16'($urandom) & mask; y = 16'($urandom) & mask;
        end
        a = s ? sx(longint'(x), w) : longint'(x);
        b = s ? sx(longint'(y), w) : longint'(y);
        p = a * b;
        for (int i = 0; i < w; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send_row(mk_row(w, s, x, y, i, 1'($urandom)), i == w-1);
        end
        get_prod($sformatf("rnd_d%0d_f%0d", d, f),
                 32'(p & ((longint'(1) << (2*w)) - 1)), 1'b0, $urandom_range(0, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
